// File: rtl/servo_pkg.sv
// Shared definitions for the servo motion path: sequencer state encoding,
// the default pulse width, the common pulse clamp range and a saturating helper.
package servo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam logic [15:0] PULSE_DEFAULT_US = 16'd1500;
    localparam int          MIN_US_DEFAULT   = 500;
    localparam int          MAX_US_DEFAULT   = 2500;

    // Width of the signed position accumulator; wide enough that
    // start + 255*step can never wrap before it is clamped.
    localparam int POS_W = 26;

    // Clamp a signed position (in us) into min_us..max_us.
    function automatic logic [15:0] saturate_us(
        input logic signed [POS_W-1:0] value,
        input int                      min_us,
        input int                      max_us
    );
        logic signed [POS_W-1:0] lo;
        logic signed [POS_W-1:0] hi;
        lo = POS_W'(min_us);
        hi = POS_W'(max_us);
        if (value < lo) begin
            return lo[15:0];
        end else if (value > hi) begin
            return hi[15:0];
        end else begin
            return value[15:0];
        end
    endfunction

endpackage

// File: rtl/servo_pan_sequencer_frame_tick_gen.sv
// Free-running frame timer: emits a one-cycle strobe once every FRAME_US
// microseconds. Also usable by the PWM generator to align its frames.
module frame_tick_gen #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int FRAME_US = 20_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic frame_tick
);

    localparam int PERIOD = FRAME_US * (CLK_FREQ / 1_000_000);
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count;

    // Count cycles and strobe on wrap so the period is exactly PERIOD cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            frame_tick <= 1'b0;
        end else if (count == LAST) begin
            count      <= '0;
            frame_tick <= 1'b1;
        end else begin
            count      <= count + CNT_W'(1);
            frame_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/servo_pan_sequencer.sv
// Servo pan sequencer: accepts goto/sweep commands, slew-limits pulse_us once
// per frame, dwells for settling and handshakes a camera capture per sweep point.
module servo_pan_sequencer
    import servo_pkg::*;
#(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int FRAME_US      = 20_000,
    parameter int MIN_US        = MIN_US_DEFAULT,
    parameter int MAX_US        = MAX_US_DEFAULT,
    parameter int SLEW_US       = 10,
    parameter int SETTLE_FRAMES = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_sweep,
    input  logic [15:0] cmd_start_us,
    input  logic [15:0] cmd_step_us,
    input  logic [7:0]  cmd_count,
    input  logic        abort,
    input  logic        cap_done,
    output logic [15:0] pulse_us,
    output logic        frame_tick,
    output logic        cap_trig,
    output logic [7:0]  pos_idx,
    output logic        busy,
    output logic        done,
    output logic        aborted
);

    localparam logic [15:0] SLEW        = 16'(SLEW_US);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_FRAMES - 1);

    state_t                  state;
    logic                    sweep_mode;
    logic signed [POS_W-1:0] acc_us;
    logic signed [POS_W-1:0] step_us;
    logic [7:0]              count;
    logic [15:0]             target_us;
    logic [15:0]             settle_cnt;
    logic [15:0]             slewed_us;
    logic signed [POS_W-1:0] start_ext;
    logic signed [POS_W-1:0] step_ext;
    logic signed [POS_W-1:0] next_acc;

    frame_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .FRAME_US (FRAME_US)
    ) u_frame_tick_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick)
    );

    assign start_ext = signed'({10'd0, cmd_start_us});
    assign step_ext  = {{10{cmd_step_us[15]}}, cmd_step_us};
    assign next_acc  = acc_us + step_us;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // One slew-limited step of pulse_us toward the current target.
    always_comb begin
        slewed_us = pulse_us;
        if (target_us > pulse_us) begin
            if (target_us - pulse_us > SLEW) slewed_us = pulse_us + SLEW;
            else                             slewed_us = target_us;
        end else if (target_us < pulse_us) begin
            if (pulse_us - target_us > SLEW) slewed_us = pulse_us - SLEW;
            else                             slewed_us = target_us;
        end
    end

    // Sequencer FSM with the position/target datapath; abort beats cap_done beats frame_tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sweep_mode <= 1'b0;
            acc_us     <= '0;
            step_us    <= '0;
            count      <= '0;
            target_us  <= PULSE_DEFAULT_US;
            settle_cnt <= '0;
            pulse_us   <= PULSE_DEFAULT_US;
            pos_idx    <= '0;
            cap_trig   <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            cap_trig <= 1'b0;
            done     <= 1'b0;
            if (state != ST_IDLE && abort) begin
                state   <= ST_IDLE;
                done    <= 1'b1;
                aborted <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cmd_valid) begin
                            sweep_mode <= cmd_sweep;
                            acc_us     <= start_ext;
                            step_us    <= step_ext;
                            count      <= cmd_count;
                            target_us  <= saturate_us(start_ext, MIN_US, MAX_US);
                            settle_cnt <= '0;
                            pos_idx    <= '0;
                            aborted    <= 1'b0;
                            state      <= ST_MOVE;
                        end
                    end
                    ST_MOVE: begin
                        if (sweep_mode && count == 8'd0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else if (frame_tick) begin
                            pulse_us <= slewed_us;
                            if (slewed_us == target_us) begin
                                settle_cnt <= '0;
                                state      <= ST_SETTLE;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (frame_tick) begin
                            if (settle_cnt == SETTLE_LAST) begin
                                if (sweep_mode) begin
                                    state    <= ST_CAPTURE;
                                    cap_trig <= 1'b1;
                                end else begin
                                    state <= ST_DONE;
                                    done  <= 1'b1;
                                end
                            end else begin
                                settle_cnt <= settle_cnt + 16'd1;
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        if (cap_done) begin
                            if (pos_idx == count - 8'd1) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                pos_idx   <= pos_idx + 8'd1;
                                acc_us    <= next_acc;
                                target_us <= saturate_us(next_acc, MIN_US, MAX_US);
                                state     <= ST_MOVE;
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
